mmio_uart_fifo: RTL and testbench

//  MMIO-mapped UART with its own TX/RX shift engines, TX/RX FIFOs, runtime frame format
//  (5-8 data bits, optional even/odd parity, 1/2 stop bits), sticky error status and a

---
 rtl/mmio_uart_fifo.sv | 340 ++++++++++++++++++++++++++++++++++
 tb/tb_mmio_uart_fifo.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_fifo.sv
`default_nettype none
// ============================================================================
// mmio_uart_fifo : MMIO UART with TX/RX FIFOs, runtime frame format, W1C status
// Optional build macro UART_LOOPBACK_EN enables the CTRL[6] internal loopback.
// Revision: 1.0
// ============================================================================
module mmio_uart_fifo #(
    parameter int A_WIDTH   = 8,
    parameter int D_WIDTH   = 32,
    parameter int TX_DEPTH  = 16,
    parameter int RX_DEPTH  = 16,
    parameter int DIV_WIDTH = 16
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               wr_en_i,
    input  logic [A_WIDTH-1:0] wr_addr_i,
    input  logic [D_WIDTH-1:0] wr_data_i,
    input  logic               rd_en_i,
    input  logic [A_WIDTH-1:0] rd_addr_i,
    output logic [D_WIDTH-1:0] rd_data_o,
    input  logic               rx_i,
    output logic               tx_o,
    output logic               irq_o
);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int TCW = TAW + 1;
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int RCW = RAW + 1;

    typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4} state_t;

    function automatic logic [DIV_WIDTH-1:0] eff_div(input logic [DIV_WIDTH-1:0] d);
        return (d < DIV_WIDTH'(4)) ? DIV_WIDTH'(4) : d;
    endfunction

    function automatic logic [7:0] data_mask(input logic [1:0] db);
        return 8'hFF >> (2'd3 - db);
    endfunction

    logic [DIV_WIDTH-1:0] div_q;
    logic       en, par_en, par_odd, stop2, ie_rx, ie_tx, ie_err;
    logic [1:0] dbits;
    logic       tx_ovf, rx_ovr, frm_seen, par_seen;
    logic       tx_bit, rx_src;
`ifdef UART_LOOPBACK_EN
    logic       lpbk;
`endif

    logic [2:0] wr_sel, rd_sel;
    logic       wr_div, wr_ctrl, wr_txd, wr_stat;
    logic       unused;
    assign wr_sel  = wr_addr_i[4:2];
    assign rd_sel  = rd_addr_i[4:2];
    assign wr_div  = wr_en_i && (wr_sel == 3'd0);
    assign wr_ctrl = wr_en_i && (wr_sel == 3'd1);
    assign wr_txd  = wr_en_i && (wr_sel == 3'd2);
    assign wr_stat = wr_en_i && (wr_sel == 3'd4);
    assign unused  = ^{wr_addr_i, rd_addr_i, wr_data_i};

    // ---------------- TX FIFO ----------------
    logic [7:0]     tx_mem [TX_DEPTH];
    logic [TAW-1:0] tx_wp, tx_rp;
    logic [TCW-1:0] tx_count;
    logic           tx_full, tx_empty, tx_push, tx_pop, tx_ovf_set;
    logic [7:0]     tx_head;

    assign tx_full    = (tx_count == TCW'(TX_DEPTH));
    assign tx_empty   = (tx_count == '0);
    assign tx_head    = tx_mem[tx_rp];
    assign tx_push    = wr_txd && en && (!tx_full || tx_pop);
    assign tx_ovf_set = wr_txd && en && tx_full && !tx_pop;

    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem[tx_wp] <= wr_data_i[7:0];
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tx_wp <= '0; tx_rp <= '0; tx_count <= '0;
        end else if (!en) begin
            tx_wp <= '0; tx_rp <= '0; tx_count <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + TAW'(1);
            if (tx_pop)  tx_rp <= tx_rp + TAW'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + TCW'(1);
                2'b01:   tx_count <= tx_count - TCW'(1);
                default: tx_count <= tx_count;
            endcase
        end
    end

    // ---------------- TX engine ----------------
    state_t               tx_state, tx_next;
    logic [DIV_WIDTH-1:0] tx_tick, tx_div;
    logic [2:0]           tx_idx;
    logic                 tx_stop_idx, tx_par, tx_fpar, tx_fstop2;
    logic [1:0]           tx_fdbits;
    logic [7:0]           tx_sh;
    logic                 tx_last;

    assign tx_last = (tx_tick == tx_div - DIV_WIDTH'(1));

    always_comb begin
        tx_next = tx_state;
        tx_pop  = 1'b0;
        case (tx_state)
            IDLE: if (!tx_empty) begin tx_pop = 1'b1; tx_next = START; end
            START: if (tx_last) tx_next = DATA;
            DATA: if (tx_last && tx_idx == {1'b1, tx_fdbits}) tx_next = tx_fpar ? PARITY : STOP;
            PARITY: if (tx_last) tx_next = STOP;
            STOP: if (tx_last && tx_stop_idx == tx_fstop2) begin
                // chain straight into the next START with no idle bit
                if (!tx_empty) begin tx_pop = 1'b1; tx_next = START; end
                else tx_next = IDLE;
            end
            default: tx_next = IDLE;
        endcase
        if (!en) begin
            tx_next = IDLE;
            tx_pop  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tx_state <= IDLE; tx_tick <= '0; tx_div <= DIV_WIDTH'(4);
            tx_idx <= '0; tx_stop_idx <= 1'b0; tx_par <= 1'b0;
            tx_fpar <= 1'b0; tx_fstop2 <= 1'b0; tx_fdbits <= '0; tx_sh <= '0;
        end else begin
            tx_state <= tx_next;
            tx_tick  <= (tx_state == IDLE || tx_last || !en) ? '0 : tx_tick + DIV_WIDTH'(1);
            if (tx_pop) begin
                tx_sh       <= tx_head & data_mask(dbits);
                tx_par      <= (^(tx_head & data_mask(dbits))) ^ par_odd;
                tx_div      <= eff_div(div_q);
                tx_fpar     <= par_en;
                tx_fstop2   <= stop2;
                tx_fdbits   <= dbits;
                tx_idx      <= '0;
                tx_stop_idx <= 1'b0;
            end else begin
                if (tx_state == DATA && tx_last) begin
                    tx_sh  <= tx_sh >> 1;
                    tx_idx <= tx_idx + 3'd1;
                end
                if (tx_state == STOP && tx_last) tx_stop_idx <= 1'b1;
            end
        end
    end

    always_comb begin
        tx_bit = 1'b1;
        if (en) begin
            case (tx_state)
                START:   tx_bit = 1'b0;
                DATA:    tx_bit = tx_sh[0];
                PARITY:  tx_bit = tx_par;
                default: tx_bit = 1'b1;
            endcase
        end
    end

`ifdef UART_LOOPBACK_EN
    assign rx_src = lpbk ? tx_bit : rx_i;
    assign tx_o   = lpbk ? 1'b1 : tx_bit;
`else
    assign rx_src = rx_i;
    assign tx_o   = tx_bit;
`endif

    // ---------------- RX engine ----------------
    logic                 rx_s1, rx_s2, rx_prev;
    state_t               rx_state, rx_next;
    logic [DIV_WIDTH-1:0] rx_tick, rx_div;
    logic [2:0]           rx_idx;
    logic [7:0]           rx_sh, rx_data;
    logic                 rx_pe, rx_fpar, rx_fodd, rx_push_req;
    logic [1:0]           rx_fdbits;
    logic                 rx_last, rx_mid;

    assign rx_last = (rx_tick == rx_div - DIV_WIDTH'(1));
    assign rx_mid  = (rx_tick == (rx_div >> 1));
    assign rx_data = rx_sh >> (2'd3 - rx_fdbits);

    always_comb begin
        rx_next     = rx_state;
        rx_push_req = 1'b0;
        case (rx_state)
            IDLE: if (rx_prev && !rx_s2) rx_next = START;
            START: begin
                if (rx_mid && rx_s2) rx_next = IDLE;
                else if (rx_last)    rx_next = DATA;
            end
            DATA: if (rx_last && rx_idx == {1'b1, rx_fdbits}) rx_next = rx_fpar ? PARITY : STOP;
            PARITY: if (rx_last) rx_next = STOP;
            STOP: if (rx_mid) begin rx_next = IDLE; rx_push_req = 1'b1; end
            default: rx_next = IDLE;
        endcase
        if (!en) begin
            rx_next     = IDLE;
            rx_push_req = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_s1 <= 1'b1; rx_s2 <= 1'b1; rx_prev <= 1'b1;
            rx_state <= IDLE; rx_tick <= '0; rx_div <= DIV_WIDTH'(4);
            rx_idx <= '0; rx_sh <= '0; rx_pe <= 1'b0;
            rx_fpar <= 1'b0; rx_fodd <= 1'b0; rx_fdbits <= '0;
        end else begin
            rx_s1    <= rx_src;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_state <= rx_next;
            rx_tick  <= (rx_state == IDLE || rx_next != rx_state || rx_last) ? '0 : rx_tick + DIV_WIDTH'(1);
            if (rx_state == IDLE && rx_next == START) begin
                rx_div    <= eff_div(div_q);
                rx_fpar   <= par_en;
                rx_fodd   <= par_odd;
                rx_fdbits <= dbits;
                rx_idx    <= '0;
                rx_pe     <= 1'b0;
            end
            if (rx_state == DATA) begin
                if (rx_mid)  rx_sh  <= {rx_s2, rx_sh[7:1]};
                if (rx_last) rx_idx <= rx_idx + 3'd1;
            end
            if (rx_state == PARITY && rx_mid) rx_pe <= (rx_s2 != ((^rx_data) ^ rx_fodd));
        end
    end

    // ---------------- RX FIFO ----------------
    logic [9:0]     rx_mem [RX_DEPTH];
    logic [RAW-1:0] rx_wp, rx_rp;
    logic [RCW-1:0] rx_count;
    logic           rx_full, rx_empty, rx_push, rx_pop, rx_ovr_set;
    logic [9:0]     rx_head;

    assign rx_full    = (rx_count == RCW'(RX_DEPTH));
    assign rx_empty   = (rx_count == '0);
    assign rx_head    = rx_mem[rx_rp];
    assign rx_pop     = rd_en_i && (rd_sel == 3'd3) && !rx_empty;
    assign rx_push    = rx_push_req && (!rx_full || rx_pop);
    assign rx_ovr_set = rx_push_req && rx_full && !rx_pop;

    always_ff @(posedge clk_i) begin
        if (rx_push) rx_mem[rx_wp] <= {rx_pe, !rx_s2, rx_data};
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_wp <= '0; rx_rp <= '0; rx_count <= '0;
        end else if (!en) begin
            rx_wp <= '0; rx_rp <= '0; rx_count <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + RAW'(1);
            if (rx_pop)  rx_rp <= rx_rp + RAW'(1);
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + RCW'(1);
                2'b01:   rx_count <= rx_count - RCW'(1);
                default: rx_count <= rx_count;
            endcase
        end
    end

    // ---------------- registers, status, read port, interrupt ----------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            div_q <= '0; en <= 1'b0; par_en <= 1'b0; par_odd <= 1'b0; stop2 <= 1'b0;
            dbits <= '0; ie_rx <= 1'b0; ie_tx <= 1'b0; ie_err <= 1'b0;
            tx_ovf <= 1'b0; rx_ovr <= 1'b0; frm_seen <= 1'b0; par_seen <= 1'b0;
        end else begin
            if (wr_div) div_q <= wr_data_i[DIV_WIDTH-1:0];
            if (wr_ctrl) begin
                en      <= wr_data_i[0];
                par_en  <= wr_data_i[1];
                par_odd <= wr_data_i[2];
                stop2   <= wr_data_i[3];
                dbits   <= wr_data_i[5:4];
                ie_rx   <= wr_data_i[8];
                ie_tx   <= wr_data_i[9];
                ie_err  <= wr_data_i[10];
            end
            // a new event in the same cycle as its W1C keeps the bit set
            tx_ovf   <= (tx_ovf   && !(wr_stat && wr_data_i[4])) || tx_ovf_set;
            rx_ovr   <= (rx_ovr   && !(wr_stat && wr_data_i[5])) || rx_ovr_set;
            frm_seen <= (frm_seen && !(wr_stat && wr_data_i[6])) || (rx_push_req && !rx_s2);
            par_seen <= (par_seen && !(wr_stat && wr_data_i[7])) || (rx_push_req && rx_pe);
        end
    end

`ifdef UART_LOOPBACK_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)     lpbk <= 1'b0;
        else if (wr_ctrl) lpbk <= wr_data_i[6];
    end
`endif

    logic [D_WIDTH-1:0] rd_val;
    always_comb begin
        rd_val = '0;
        case (rd_sel)
            3'd0: rd_val[DIV_WIDTH-1:0] = div_q;
            3'd1: begin
                rd_val[5:0]  = {dbits, stop2, par_odd, par_en, en};
                rd_val[10:8] = {ie_err, ie_tx, ie_rx};
`ifdef UART_LOOPBACK_EN
                rd_val[6]    = lpbk;
`endif
            end
            3'd2: begin
                rd_val[8]         = tx_full;
                rd_val[16 +: TCW] = tx_count;
            end
            3'd3: if (!rx_empty) rd_val[10:0] = {rx_head[9:8], 1'b1, rx_head[7:0]};
            3'd4: begin
                rd_val[7:0]       = {par_seen, frm_seen, rx_ovr, tx_ovf, rx_full, rx_empty, tx_empty, tx_full};
                rd_val[16 +: RCW] = rx_count;
            end
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_data_o <= '0;
            irq_o     <= 1'b0;
        end else begin
            if (rd_en_i) rd_data_o <= rd_val;
            irq_o <= en && ((ie_rx && !rx_empty) ||
                            (ie_tx && tx_empty && tx_state == IDLE) ||
                            (ie_err && (tx_ovf || rx_ovr || frm_seen || par_seen)));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_fifo.sv
`default_nettype none
// ============================================================================
// tb_mmio_uart_fifo : register table vectors plus directed serial sequences
// Revision: 1.0
// ============================================================================
module tb_mmio_uart_fifo;
    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        wr_en_i, rd_en_i;
    logic [7:0]  wr_addr_i, rd_addr_i;
    logic [31:0] wr_data_i;
    logic [31:0] rd_data_o;
    logic        rx_i;
    logic        tx_o, irq_o;

    mmio_uart_fifo dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
        .rx_i(rx_i), .tx_o(tx_o), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

`ifdef UART_LOOPBACK_EN
    localparam logic [31:0] CTRL_RB = 32'h0000_077E;
`else
    localparam logic [31:0] CTRL_RB = 32'h0000_073E;
`endif

    vec_t vq[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   bitp = 8;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add_vec(input bit wr, input logic [7:0] a, input logic [31:0] d, input logic [31:0] e);
        vec_t v;
        v.wr = wr; v.addr = a; v.data = d; v.exp = e;
        vq.push_back(v);
    endtask

    task automatic reg_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk_i);
        wr_en_i = 1'b1; wr_addr_i = a; wr_data_i = d;
        @(negedge clk_i);
        wr_en_i = 1'b0;
    endtask

    task automatic reg_read(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk_i);
        rd_en_i = 1'b1; rd_addr_i = a;
        @(negedge clk_i);
        rd_en_i = 1'b0;
        d = rd_data_o;
    endtask

    task automatic read_check(input string name, input logic [7:0] a, input logic [31:0] e);
        logic [31:0] d;
        reg_read(a, d);
        check(name, d, e);
    endtask

    task automatic drive_bit(input logic b);
        rx_i = b;
        repeat (bitp) @(negedge clk_i);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nb, input bit pen, input bit podd,
                              input int nstop, input bit bad_par, input bit stop_low);
        logic p;
        @(negedge clk_i);
        p = podd;
        for (int i = 0; i < nb; i++) p = p ^ d[i];
        if (bad_par) p = ~p;
        drive_bit(1'b0);
        for (int i = 0; i < nb; i++) drive_bit(d[i]);
        if (pen) drive_bit(p);
        for (int s = 0; s < nstop; s++) drive_bit(stop_low ? 1'b0 : 1'b1);
        rx_i = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] txexp;
        bit         found, hi_bad;
        logic [31:0] d;

        rst_n_i = 1'b0; wr_en_i = 1'b0; rd_en_i = 1'b0;
        wr_addr_i = '0; rd_addr_i = '0; wr_data_i = '0; rx_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check("rst_rd_data", rd_data_o, 32'h0);
        check("rst_tx", {31'b0, tx_o}, 32'h1);
        check("rst_irq", {31'b0, irq_o}, 32'h0);
        rst_n_i = 1'b1;

        // register-map vectors
        add_vec(0, 8'h00, 0, 32'h0);
        add_vec(0, 8'h04, 0, 32'h0);
        add_vec(0, 8'h08, 0, 32'h0);
        add_vec(0, 8'h0C, 0, 32'h0);
        add_vec(0, 8'h10, 0, 32'h6);
        add_vec(0, 8'h14, 0, 32'h0);
        add_vec(1, 8'h00, 32'hFFFF_1234, 0);
        add_vec(0, 8'h00, 0, 32'h1234);
        add_vec(0, 8'h03, 0, 32'h1234);
        add_vec(1, 8'h04, 32'hFFFF_F77E, 0);
        add_vec(0, 8'h04, 0, CTRL_RB);
        add_vec(1, 8'h1C, 32'hFFFF_FFFF, 0);
        add_vec(0, 8'h1C, 0, 32'h0);
        add_vec(0, 8'h00, 0, 32'h1234);
        add_vec(1, 8'h08, 32'h0000_00AB, 0);
        add_vec(0, 8'h10, 0, 32'h6);
        add_vec(0, 8'h08, 0, 32'h0);
        add_vec(1, 8'h10, 32'h0000_00F0, 0);
        add_vec(0, 8'h10, 0, 32'h6);
        for (int i = 0; i < vq.size(); i++) begin
            if (vq[i].wr) reg_write(vq[i].addr, vq[i].data);
            else read_check($sformatf("vec%0d_addr%02h", i, vq[i].addr), vq[i].addr, vq[i].exp);
        end
        check("irq_en_off", {31'b0, irq_o}, 32'h0);
        reg_write(8'h04, 32'h0);

        // TX 8N1 of 0xA5 at DIV=8
        reg_write(8'h00, 32'd8);
        reg_write(8'h04, 32'h31);
        reg_write(8'h08, 32'hA5);
        txexp = 10'b1_1010_0101_0;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (tx_o == 1'b0) begin found = 1'b1; break; end
            @(negedge clk_i);
        end
        check("tx_start_seen", {31'b0, found}, 32'h1);
        if (found) begin
            for (int t = 0; t < 80; t++) begin
                if (t % 8 == 0 || t % 8 == 7)
                    check($sformatf("tx_bit_t%0d", t), {31'b0, tx_o}, {31'b0, txexp[t / 8]});
                @(negedge clk_i);
            end
        end
        read_check("tx_done_stat", 8'h10, 32'h6);

        // RX 5 bits, odd parity, 2 stop
        reg_write(8'h04, 32'h0F);
        send_frame(8'h13, 5, 1, 1, 2, 0, 0);
        repeat (4) @(negedge clk_i);
        read_check("rx_5o2", 8'h0C, 32'h113);
        read_check("rx_5o2_empty", 8'h0C, 32'h0);

        // TX FIFO fill and overflow at DIV=100
        reg_write(8'h00, 32'd100);
        reg_write(8'h04, 32'h31);
        for (int i = 0; i < 17; i++) reg_write(8'h08, 32'(i));
        read_check("tx_fill_txd", 8'h08, 32'h0010_0100);
        read_check("tx_fill_stat", 8'h10, 32'h5);
        check("tx_in_flight", {31'b0, tx_o}, 32'h0);
        reg_write(8'h08, 32'h77);
        read_check("tx_ovf_stat", 8'h10, 32'h15);
        reg_write(8'h10, 32'h10);
        read_check("tx_ovf_clr", 8'h10, 32'h5);
        reg_write(8'h04, 32'h30);
        check("en_off_tx_high", {31'b0, tx_o}, 32'h1);
        read_check("en_off_stat", 8'h10, 32'h6);
        reg_write(8'h08, 32'h55);
        read_check("en_off_no_ovf", 8'h10, 32'h6);

        // RX overrun: 17 frames with nobody reading
        reg_write(8'h00, 32'd8);
        reg_write(8'h04, 32'h31);
        for (int i = 0; i < 17; i++) send_frame(8'(i + 1), 8, 0, 0, 1, 0, 0);
        repeat (4) @(negedge clk_i);
        read_check("rx_ovr_stat", 8'h10, 32'h0010_002A);
        @(negedge clk_i);
        rd_en_i = 1'b1; rd_addr_i = 8'h0C;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_i);
            if (i == 15) rd_en_i = 1'b0;
            check($sformatf("rx_burst%0d", i), rd_data_o, 32'h100 | 32'(i + 1));
        end
        read_check("rx_17th_lost", 8'h0C, 32'h0);
        reg_write(8'h10, 32'h20);
        read_check("rx_ovr_clr", 8'h10, 32'h6);

        // framing error with error interrupt
        reg_write(8'h04, 32'h431);
        send_frame(8'h5A, 8, 0, 0, 1, 0, 1);
        repeat (4) @(negedge clk_i);
        read_check("rx_frm", 8'h0C, 32'h35A);
        repeat (2) @(negedge clk_i);
        check("irq_frm", {31'b0, irq_o}, 32'h1);
        read_check("frm_stat", 8'h10, 32'h46);
        reg_write(8'h10, 32'h40);
        @(negedge clk_i);
        check("irq_frm_clr", {31'b0, irq_o}, 32'h0);

        // parity error, 8 data bits even parity
        reg_write(8'h04, 32'h33);
        send_frame(8'h01, 8, 1, 0, 1, 1, 0);
        repeat (4) @(negedge clk_i);
        read_check("rx_par", 8'h0C, 32'h501);
        read_check("par_stat", 8'h10, 32'h86);
        reg_write(8'h10, 32'h80);

        // TX-empty interrupt
        reg_write(8'h04, 32'h231);
        repeat (2) @(negedge clk_i);
        check("irq_tx_empty", {31'b0, irq_o}, 32'h1);

`ifdef UART_LOOPBACK_EN
        reg_write(8'h04, 32'h71);
        reg_write(8'h08, 32'h3C);
        hi_bad = 1'b0;
        for (int i = 0; i < 120; i++) begin
            if (tx_o !== 1'b1) hi_bad = 1'b1;
            @(negedge clk_i);
        end
        check("lpbk_tx_high", {31'b0, hi_bad}, 32'h0);
        read_check("lpbk_rx", 8'h0C, 32'h13C);
`else
        hi_bad = 1'b0;
        if (hi_bad) d = '0;
`endif
        reg_write(8'h04, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
